// File: rtl/mem_resp_pkg.sv
// Shared CPU bus constants and types used by the mem_resp memory responder.
package mem_resp_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BEN_W  = 4;

  // Bus-error encoding carried on the Err strobes.
  localparam logic BUS_OK  = 1'b0;
  localparam logic BUS_ERR = 1'b1;

  localparam int MEM_RESP_I_WAIT = 0;
  localparam int MEM_RESP_D_WAIT = 1;

  typedef enum logic {
    PS_IDLE = 1'b0,
    PS_WAIT = 1'b1
  } port_state_t;

endpackage

// File: rtl/mem_resp_port.sv
// One bus port of the memory responder: acceptance, wait-state FSM, address
// decode and Err/Rdy strobes.
module mem_resp_port
  import mem_resp_pkg::*;
#(
  parameter int                MEM_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int                WAIT      = 0,
  localparam int               AW        = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_rdy,
  output logic              o_err,
  output logic              o_accept,
  output logic              o_ok,
  output logic [AW-1:0]     o_idx
);

  localparam logic [3:0]  WAIT_M1 = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);
  localparam logic [63:0] SPAN    = 64'(MEM_WORDS) << 2;

  port_state_t       r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              r_err, w_err_nxt;
  logic [ADDR_W-1:0] w_off;

  // Offset wraps modulo 2^32, so addresses below BASE_ADDR land out of range.
  assign w_off    = i_addr - BASE_ADDR;
  assign o_ok     = (i_addr[1:0] == 2'b00) && ({32'b0, w_off} < SPAN);
  assign o_idx    = w_off[AW+1:2];
  assign o_rdy    = (r_state == PS_IDLE);
  assign o_accept = i_req & o_rdy;
  assign o_err    = r_err & o_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PS_IDLE;
      r_cnt   <= 4'd0;
      r_err   <= BUS_OK;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // r_err holds the pending result through WAIT and is shown only once Rdy returns.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    case (r_state)
      PS_IDLE: begin
        if (o_accept) begin
          w_err_nxt = o_ok ? BUS_OK : BUS_ERR;
          if (WAIT != 0) begin
            w_state_nxt = PS_WAIT;
            w_cnt_nxt   = WAIT_M1;
          end
        end else begin
          w_err_nxt = BUS_OK;
        end
      end
      PS_WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = PS_IDLE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      default: w_state_nxt = PS_IDLE;
    endcase
  end

endmodule

// File: rtl/mem_resp.sv
// Dual-port memory responder: instruction fetches on the I-Port, loads and
// stores on the D-Port, one shared word array.
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int                MEM_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int                I_WAIT    = MEM_RESP_I_WAIT,
  parameter int                D_WAIT    = MEM_RESP_D_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_IAddr,
  input  logic              i_IRdC,
  output logic [DATA_W-1:0] o_IData,
  output logic              o_IRdy,
  output logic              o_IErr,
  input  logic [ADDR_W-1:0] i_DAddr,
  input  logic              i_DCmd,
  input  logic              i_DRnW,
  input  logic [BEN_W-1:0]  i_DBen,
  input  logic [DATA_W-1:0] i_DData,
  output logic [DATA_W-1:0] o_DData,
  output logic              o_DRdy,
  output logic              o_DErr
);

  localparam int AW = $clog2(MEM_WORDS);

  logic              w_iaccept, w_iok, w_daccept, w_dok, w_dwr;
  logic [AW-1:0]     w_iidx, w_didx;
  logic [DATA_W-1:0] r_mem [MEM_WORDS];
  logic [DATA_W-1:0] r_idata, r_ddata;

  mem_resp_port #(
    .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR), .WAIT(I_WAIT)
  ) u_iport (
    .clk(clk), .rst(rst), .i_req(i_IRdC), .i_addr(i_IAddr),
    .o_rdy(o_IRdy), .o_err(o_IErr), .o_accept(w_iaccept), .o_ok(w_iok), .o_idx(w_iidx)
  );

  mem_resp_port #(
    .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR), .WAIT(D_WAIT)
  ) u_dport (
    .clk(clk), .rst(rst), .i_req(i_DCmd), .i_addr(i_DAddr),
    .o_rdy(o_DRdy), .o_err(o_DErr), .o_accept(w_daccept), .o_ok(w_dok), .o_idx(w_didx)
  );

  assign w_dwr = w_daccept & w_dok & ~i_DRnW;

  always_ff @(posedge clk) begin
    for (int k = 0; k < BEN_W; k++) begin
      if (w_dwr && i_DBen[k]) r_mem[w_didx][8*k +: 8] <= i_DData[8*k +: 8];
    end
  end

  // Reads sample the array before this edge's write, so a same-edge fetch sees old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idata <= '0;
      r_ddata <= '0;
    end else begin
      if (w_iaccept)            r_idata <= w_iok ? r_mem[w_iidx] : '0;
      if (w_daccept && i_DRnW)  r_ddata <= w_dok ? r_mem[w_didx] : '0;
    end
  end

  assign o_IData = r_idata;
  assign o_DData = r_ddata;

endmodule
